// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared encodings for the EX-stage mul/div issue controller and the unit it drives.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package mdu_issue_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int TIMEOUT_DEF = 48;
    localparam int CNT_W_DEF   = 6;

    // Instruction encodings as presented by EX on op_i
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    // Functional-unit select presented on sel_o
    typedef enum logic [1:0] {
        SEL_IDLE = 2'b00,
        SEL_MUL  = 2'b01,
        SEL_DIV  = 2'b10
    } mdu_sel_e;

    // Controller states; DRAIN lasts two cycles so the unit can walk back to free
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_DRAIN = 2'b11
    } mdu_state_e;

    // Handshake levels already used by the unit
    localparam logic UNIT_START     = 1'b1;
    localparam logic UNIT_STOP      = 1'b0;
    localparam logic UNIT_READY     = 1'b1;
    localparam logic UNIT_NOT_READY = 1'b0;

    // Divide ops have op[1] set; everything else goes to the multiplier
    function automatic logic [1:0] op_to_sel(input logic [1:0] op);
        return op[1] ? SEL_DIV : SEL_MUL;
    endfunction

    // The unsigned variants have op[0] set
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// Initiator for the multi-cycle mul/div unit: issues operands, stalls EX, commits HI/LO, drains on flush/abort.
// Latency: result write strobe nominally unit latency + 2 cycles after the issue edge; stall_o is combinational.
// Backpressure: start_o held and pipeline stalled until unit_ready_i, a flush, or the BUSY watchdog fires.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    input  logic            unit_ready_i,
    input  logic [63:0]     unit_result_i,
    output logic            start_o,
    output logic            signed_o,
    output logic [1:0]      sel_o,
    output logic [XLEN-1:0] opdata1_o,
    output logic [XLEN-1:0] opdata2_o,
    output logic            annul_o,
    output logic            stall_o,
    output logic            hilo_we_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            err_o
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    mdu_state_e        r_state;
    mdu_state_e        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_drain_cnt;
    logic              r_signed;
    logic [1:0]        r_sel;
    logic [XLEN-1:0]   r_opdata1;
    logic [XLEN-1:0]   r_opdata2;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_err;

    logic              w_issue;
    logic              w_busy;
    logic              w_ready;
    logic              w_capture;
    logic              w_timeout;
    logic              w_leave;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_ready   = (unit_ready_i == UNIT_READY);
    assign w_issue   = (r_state == ST_IDLE) & op_valid_i & ~flush_i;
    // Flush outranks a same-cycle result; the result is then simply dropped
    assign w_capture = w_busy & ~flush_i & w_ready;
    assign w_timeout = w_busy & ~flush_i & ~w_ready & (r_cnt == LP_CNT_LAST);
    assign w_leave   = (r_state != ST_IDLE) & (w_next_state == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    w_next_state = ST_DRAIN;
                end else if (w_ready) begin
                    w_next_state = ST_DONE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            ST_DRAIN: begin
                if (r_drain_cnt) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; the write strobe is killed by a flush in the same cycle
    always_comb begin
        start_o   = w_busy ? UNIT_START : UNIT_STOP;
        annul_o   = (r_state == ST_DRAIN) & ~r_drain_cnt;
        hilo_we_o = (r_state == ST_DONE) & ~flush_i;
        stall_o   = w_issue | w_busy;
    end

    // BUSY watchdog counter, cleared on every issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Two-cycle DRAIN sub-counter; reads 0 on entry so annul fires once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_cnt <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= ~r_drain_cnt;
        end else begin
            r_drain_cnt <= 1'b0;
        end
    end

    // Operand/mode capture; held until IDLE because the unit re-reads signs late
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opdata1 <= '0;
            r_opdata2 <= '0;
            r_signed  <= 1'b0;
            r_sel     <= SEL_IDLE;
        end else if (w_issue) begin
            r_opdata1 <= src_a_i;
            r_opdata2 <= src_b_i;
            r_signed  <= op_is_signed(op_i);
            r_sel     <= op_to_sel(op_i);
        end else if (w_leave) begin
            r_signed  <= 1'b0;
            r_sel     <= SEL_IDLE;
        end
    end

    // HI/LO capture on result accept; held until the next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_capture) begin
            r_hi <= unit_result_i[63:32];
            r_lo <= unit_result_i[31:0];
        end
    end

    // Sticky watchdog error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign signed_o  = r_signed;
    assign sel_o     = r_sel;
    assign opdata1_o = r_opdata1;
    assign opdata2_o = r_opdata2;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
    assign err_o     = r_err;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl with a behavioural mul/div unit of programmable latency.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic        flush_i = 1'b0;
    logic        unit_ready_i = 1'b0;
    logic [63:0] unit_result_i = '0;
    logic        start_o, signed_o, annul_o, stall_o, hilo_we_o, err_o;
    logic [1:0]  sel_o;
    logic [31:0] opdata1_o, opdata2_o, hi_o, lo_o;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.TIMEOUT(48), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
        .unit_ready_i(unit_ready_i), .unit_result_i(unit_result_i),
        .start_o(start_o), .signed_o(signed_o), .sel_o(sel_o),
        .opdata1_o(opdata1_o), .opdata2_o(opdata2_o), .annul_o(annul_o),
        .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
        .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Architectural result of a MIPS mul/div: {hi,lo}; divide gives {rem,quot}, by-zero gives 0
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return 64'd0;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Unit model plus output monitor, sampled on the falling edge
    int          unit_lat = 1;
    int          u_cnt = 0;
    int          mon_we = 0;
    int          mon_annul = 0;
    logic [31:0] mon_hi = '0;
    logic [31:0] mon_lo = '0;
    always @(negedge clk) begin
        if (hilo_we_o) begin
            mon_we = mon_we + 1;
            mon_hi = hi_o;
            mon_lo = lo_o;
        end
        if (annul_o) mon_annul = mon_annul + 1;
        if (start_o && !rst) begin
            u_cnt = u_cnt + 1;
            if (u_cnt == unit_lat) begin
                unit_ready_i  <= 1'b1;
                unit_result_i <= ref_result({sel_o == SEL_DIV, ~signed_o}, opdata1_o, opdata2_o);
            end else begin
                unit_ready_i  <= 1'b0;
            end
        end else begin
            u_cnt = 0;
            unit_ready_i <= 1'b0;
        end
    end

    // Results of the most recent do_op
    int          g_we, g_annul, g_busy, g_post;
    bit          g_stable;
    logic [1:0]  g_sel;
    logic        g_signed;

    // Issue one op from IDLE (called at posedge+1) and follow it back to IDLE
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int flush_at, input bit flush_done);
        int we0, an0, cyc;
        we0 = mon_we;
        an0 = mon_annul;
        unit_lat = lat;
        op_valid_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        #1 chk("stall_on_issue", {63'd0, stall_o}, 64'd1);
        @(posedge clk); #1;
        // Scramble EX inputs: the controller must hold its own copy
        op_valid_i = 1'b0; op_i = ~op; src_a_i = ~a; src_b_i = ~b;
        g_sel = sel_o; g_signed = signed_o;
        g_stable = 1'b1; g_busy = 0; g_post = 0; cyc = 0;
        while (sel_o != SEL_IDLE && cyc < 200) begin
            if (opdata1_o !== a || opdata2_o !== b || signed_o !== g_signed || sel_o !== g_sel)
                g_stable = 1'b0;
            if (stall_o) begin
                g_busy++;
                if (g_busy == flush_at) flush_i = 1'b1;
            end else begin
                g_post++;
                if (flush_done && g_post == 1) flush_i = 1'b1;
            end
            @(posedge clk); #1;
            flush_i = 1'b0;
            cyc++;
        end
        chk("back_to_idle", {62'd0, sel_o}, 64'd0);
        g_we = mon_we - we0;
        g_annul = mon_annul - an0;
    endtask

    // Full check of an op that completes normally
    task automatic run_ok(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat);
        do_op(op, a, b, lat, 0, 1'b0);
        chk_i({nm, "_we_pulses"}, g_we, 1);
        chk({nm, "_hi"}, {32'd0, mon_hi}, {32'd0, ehi});
        chk({nm, "_lo"}, {32'd0, mon_lo}, {32'd0, elo});
        chk({nm, "_hilo_hold"}, {hi_o, lo_o}, {ehi, elo});
        chk_i({nm, "_busy_cycles"}, g_busy, lat);
        chk_i({nm, "_post_cycles"}, g_post, 1);
        chk_i({nm, "_annul"}, g_annul, 0);
        chk_i({nm, "_operands_stable"}, int'(g_stable), 1);
        chk({nm, "_sel"}, {62'd0, g_sel}, {62'd0, op[1] ? 2'b10 : 2'b01});
        chk({nm, "_signed"}, {63'd0, g_signed}, {63'd0, ~op[0]});
    endtask

    typedef struct {
        string       nm;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"divu_100_7",  OP_DIVU,  32'd100,        32'd7, 32'd2,          32'd14,         36};
        vecs[1] = '{"div_m7_2",    OP_DIV,   32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  30};
        vecs[2] = '{"multu_max_2", OP_MULTU, 32'hFFFF_FFFF,  32'd2, 32'h0000_0001,  32'hFFFF_FFFE,  4};
        vecs[3] = '{"divu_9_3_b2b",OP_DIVU,  32'd9,          32'd3, 32'd0,          32'd3,          20};
        vecs[4] = '{"div_by_zero", OP_DIV,   32'h1234_5678,  32'd0, 32'd0,          32'd0,          36};
        vecs[5] = '{"mult_m2_3",   OP_MULT,  32'hFFFF_FFFE,  32'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFA,  1};
        vecs[6] = '{"divu_min",    OP_DIVU,  32'd5,          32'd9, 32'd5,          32'd0,          2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start",   {63'd0, start_o},   64'd0);
        chk("rst_sel",     {62'd0, sel_o},     64'd0);
        chk("rst_signed",  {63'd0, signed_o},  64'd0);
        chk("rst_opdata",  {opdata1_o, opdata2_o}, 64'd0);
        chk("rst_annul",   {63'd0, annul_o},   64'd0);
        chk("rst_hilo_we", {63'd0, hilo_we_o}, 64'd0);
        chk("rst_hilo",    {hi_o, lo_o},       64'd0);
        chk("rst_err",     {63'd0, err_o},     64'd0);
        chk("rst_stall",   {63'd0, stall_o},   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table; consecutive entries issue back-to-back on the first IDLE cycle
        for (int i = 0; i < 7; i++)
            run_ok(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

        // Flush in IDLE: op ignored, no stall, no start
        op_valid_i = 1'b1; op_i = OP_MULT; flush_i = 1'b1;
        #1 chk("idle_flush_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        op_valid_i = 1'b0; flush_i = 1'b0;
        chk("idle_flush_no_start", {61'd0, start_o, sel_o}, 64'd0);

        // Flush on the 10th BUSY cycle
        do_op(OP_DIV, 32'd1000, 32'd3, 30, 10, 1'b0);
        chk_i("flush10_we", g_we, 0);
        chk_i("flush10_annul", g_annul, 1);
        chk_i("flush10_busy", g_busy, 10);
        chk_i("flush10_drain", g_post, 2);
        run_ok("mult_3_4_after_flush", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 6);

        // Flush coincident with unit ready: flush wins
        do_op(OP_MULTU, 32'd7, 32'd7, 5, 5, 1'b0);
        chk_i("flush_ready_we", g_we, 0);
        chk_i("flush_ready_annul", g_annul, 1);
        chk_i("flush_ready_drain", g_post, 2);
        chk("flush_ready_hilo_kept", {hi_o, lo_o}, 64'd12);

        // Flush during DONE: write suppressed, no drain
        do_op(OP_DIVU, 32'd50, 32'd5, 3, 0, 1'b1);
        chk_i("flush_done_we", g_we, 0);
        chk_i("flush_done_annul", g_annul, 0);
        chk_i("flush_done_post", g_post, 1);

        // Randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            logic [63:0] rr;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (i == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rop = OP_MULT; end
            rr = ref_result(rop, ra, rb);
            run_ok($sformatf("rand%0d", i), rop, ra, rb, rr[63:32], rr[31:0], $urandom_range(1, 36));
        end

        // Unit never ready: watchdog after 48 BUSY cycles
        chk("err_before_timeout", {63'd0, err_o}, 64'd0);
        do_op(OP_DIVU, 32'd1, 32'd1, 100000, 0, 1'b0);
        chk_i("timeout_busy", g_busy, 48);
        chk_i("timeout_drain", g_post, 2);
        chk_i("timeout_annul", g_annul, 1);
        chk_i("timeout_we", g_we, 0);
        chk("timeout_err", {63'd0, err_o}, 64'd1);
        repeat (3) @(posedge clk);
        #1 chk("err_sticky", {63'd0, err_o}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("err_cleared_by_rst", {63'd0, err_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Initiator side of the multi-cycle multiply/divide unit interface; sits in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU from EX, drives start/signed/sel/operands to the unit, and stalls the pipeline until the result is ready.
- Commits the 64-bit result to HI/LO as a one-cycle write, and cancels in-flight operations on pipeline flush using annul plus a drain sequence.

Parameters:
- TIMEOUT, 48, maximum BUSY cycles before watchdog abort (must exceed worst-case unit latency of 36).
- CNT_W, 6, width of the BUSY cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid_i  in  1  EX holds a mul/div instruction this cycle
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a_i  in  32  rs operand (multiplicand/dividend)
- src_b_i  in  32  rt operand (multiplier/divisor)
- flush_i  in  1  pipeline flush; squashes the EX instruction
- unit_ready_i  in  1  unit result valid
- unit_result_i  in  64  unit result: {rem,quot} for divide, {hi,lo} product for multiply
- start_o  out  1  unit start; held high until the result is taken
- signed_o  out  1  signed operation
- sel_o  out  2  10 divide, 01 multiply, 00 idle
- opdata1_o  out  32  operand 1 to unit
- opdata2_o  out  32  operand 2 to unit
- annul_o  out  1  unit cancel
- stall_o  out  1  stall request to pipeline control
- hilo_we_o  out  1  HI/LO write strobe
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data
- err_o  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE. All outputs 0: start, signed, sel, opdata1/2, annul, hilo_we, hi, lo, err. BUSY counter cleared.
- States: IDLE, BUSY, DONE, DRAIN (2 cycles, sub-counter).
- stall_o is combinational: (IDLE & op_valid_i & ~flush_i) | BUSY. It is 0 in DONE and DRAIN.
- IDLE:
  - op_valid_i & ~flush_i: register opdata1/2 = src_a/src_b. Set signed_o = ~op_i[0], sel_o = op_i[1] ? 10 : 01, start_o = 1, clear counter. Next state BUSY.
  - flush_i: ignore op; no start issued.
- Operand hold: opdata1/2, signed_o and sel_o stay frozen from the issue edge until the state returns to IDLE. The unit re-reads operand signs during its post-compute correction, so they must not change early.
- BUSY: start_o = 1; counter increments each cycle.
  - flush_i wins over all other events, including a simultaneous unit_ready_i: go to DRAIN.
  - Else if unit_ready_i: register hi_o = unit_result_i[63:32] and lo_o = unit_result_i[31:0]; set start_o = 0; go to DONE.
  - Else if counter == TIMEOUT-1: set err_o = 1 (sticky until rst); go to DRAIN.
- DONE (1 cycle): hilo_we_o = 1 unless flush_i this cycle, in which case the write is suppressed. start_o = 0. Next state IDLE; sel_o returns to 00.
- DRAIN: start_o = 0; annul_o = 1 on the first DRAIN cycle only. Stay 2 cycles so the unit passes its by-zero/end states back to free, then go to IDLE. No HI/LO write.
- Back-to-back: an op in IDLE on the cycle after DONE may start immediately, because the unit returns to free on that same edge.
- Divide by zero: no special handling. The unit returns 0, so hi = lo = 0 and hilo_we pulses once.
- Nominal latency, issue edge to hilo_we: unit latency + 2 cycles.
- hilo_we_o is a single-cycle pulse. hi_o/lo_o hold their value until the next capture.

Decomposition:
- Shared package: op encodings (MULT/MULTU/DIV/DIVU), sel codes (SEL_DIV = 10, SEL_MUL = 01, SEL_IDLE = 00), state encodings, and the start/stop and ready/not-ready constants already used by the unit.
- No sub-module. The watchdog counter is inline.

Test Plan:
- DIVU 100, 7 against the unit model: one hilo_we pulse, hi = 2, lo = 14; stall_o high from the issue cycle through BUSY.
- DIV 0xFFFFFFF9 (-7), 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; opdata1/2 stable until IDLE.
- MULTU 0xFFFFFFFF, 2: hi = 0x00000001, lo = 0xFFFFFFFE. A back-to-back DIVU 9, 3 issues in the cycle after DONE and gives hi = 0, lo = 3.
- DIV x, 0: hi = lo = 0, exactly one hilo_we pulse.
- flush_i on the 10th BUSY cycle: annul_o pulses once, no hilo_we, 2 DRAIN cycles. The next MULT 3, 4 gives lo = 12.
- unit_ready_i tied 0: err_o rises after 48 BUSY cycles, then DRAIN, then IDLE, and no hilo_we.
